kbd_cmd_sequencer: RTL and testbench
====================================

KBD_CMD_SEQUENCER -- requirements
Module: kbd_cmd_sequencer

Interface
REQ-001 Parameter ACK_TIMEOUT, default 2000: cycles allowed in WAIT_ACK before a timeout.
REQ-002 Parameter MAX_RETRY, default 2: retransmissions allowed per command byte after the first attempt.
REQ-003 KBD_CLK  in  1  sole clock; all logic on rising edge.
REQ-004 KBD_RESET_N  in  1  reset, synchronous, active-low.
REQ-005 tx_data  out  8  byte presented to the keyboard serial transmitter.
REQ-006 tx_start  out  1  one-cycle pulse; tx_data is valid in the same cycle.
REQ-007 tx_busy  in  1  transmitter busy; high from the cycle after tx_start until the frame ends.
REQ-008 rx_data  in  8  byte from the keyboard serial receiver.
REQ-009 rx_valid  in  1  one-cycle strobe qualifying rx_data.
REQ-010 cmd_valid / cmd_data  in  1 / 8  host command request and byte.
REQ-011 cmd_ready  out  1  host command accepted in any cycle where cmd_valid&&cmd_ready.
REQ-012 cmd_done  out  1  one-cycle pulse when a host command is acknowledged (FA).
REQ-013 scan_valid / scan_data  out  1 / 8  one-cycle strobe plus forwarded scan byte.
REQ-014 init_done  out  1  high once the init sequence completes.
REQ-015 err  out  1  sticky failure flag.

Function
REQ-016 The states SHALL be INIT_SEND, INIT_TXW, INIT_ACK, READY, HOST_TXW, HOST_ACK and ERROR.
REQ-017 The init ROM SHALL be F4, F0, 01, with index idx 0..2.
REQ-018 INIT_SEND: pulse tx_start with tx_data=ROM[idx]; go to INIT_TXW.
REQ-019 INIT_TXW/HOST_TXW: wait for tx_busy to fall after having been seen high; then go to *_ACK and clear the timeout counter.
REQ-020 *_ACK, rx_valid with rx_data=FA: clear the retry count.
 - Init: idx<2 increments idx and goes to INIT_SEND; idx=2 sets init_done and goes to READY.
 - Host: pulses cmd_done and goes to READY.
REQ-021 *_ACK, counter reaching ACK_TIMEOUT-1 with no FA: if retries<MAX_RETRY, increment retries and resend the same byte; otherwise go to ERROR.
REQ-022 INIT_ACK, rx_valid with a byte other than FA (or FE, see REQ-031): the byte SHALL be discarded.
REQ-023 HOST_ACK, rx_valid with a byte other than FA/FE: the byte SHALL be forwarded as a scan byte and the wait SHALL continue.
REQ-024 cmd_ready SHALL equal (state==READY && !tx_busy).
 - On accept: latch cmd_data, pulse tx_start with it on the next cycle, then go to HOST_TXW.
REQ-025 READY/HOST_ACK scan forwarding: scan_valid/scan_data SHALL be registered from rx_valid/rx_data, giving 1-cycle latency.
REQ-026 rx_valid and command accept in the same READY cycle SHALL both be serviced with no loss.
REQ-027 ERROR SHALL set err=1, hold cmd_ready=0, and suppress scan_valid until reset.
REQ-028 A timeout coinciding with an FA in the same cycle SHALL resolve as FA.

Reset
REQ-029 While KBD_RESET_N=0 at a clock edge: state=INIT_SEND, idx=0, retries=0, counter=0.
 - tx_start, cmd_ready, cmd_done, scan_valid, init_done and err SHALL be 0.
 - tx_data and scan_data SHALL be 00.
REQ-030 Reset asserted mid-frame or mid-wait SHALL abandon the operation; init SHALL restart from F4 one cycle after release.

Configuration
REQ-031 With KBD_CMD_RESEND_EN defined, rx_data=FE in *_ACK SHALL be handled like a timeout (retry or ERROR per REQ-021).
 - Without the macro, FE in INIT_ACK SHALL be discarded and FE in HOST_ACK forwarded as a scan byte.

Structure
REQ-032 Package kbd_pkg SHALL hold the state enum, the ACK (FA), RESEND (FE) and init ROM constants, and the default parameter values.
REQ-033 The timeout/retry counter SHALL be one sub-module, kbd_ack_timer, with clear, enable and expired ports; the FSM SHALL be in the top module.

Verification
REQ-034 Release reset; model transmitter busy 12 cycles; reply FA after each frame.
 - Required: tx bytes F4, F0, 01 in order; init_done=1 after the third FA; err=0.
REQ-035 Init with no reply to F0, ACK_TIMEOUT=50, MAX_RETRY=2.
 - Required: F0 sent three times, spaced at least 50 cycles apart; then err=1, and cmd_ready stays 0.
REQ-036 In READY, rx 1C then 32.
 - Required: scan_valid pulses one cycle after each strobe, with scan_data 1C then 32.
REQ-037 In READY, cmd_valid with ED plus simultaneous rx_valid 1C; during HOST_ACK rx 2A, then FA.
 - Required: tx ED; scan bytes 1C and 2A; one cmd_done pulse.
REQ-038 With KBD_CMD_RESEND_EN, reply FE to F4 once, then FA.
 - Required: F4 is retransmitted once and init proceeds to F0.
 - Without the macro: FE is ignored and the same stimulus times out instead.
REQ-039 Assert reset during INIT_TXW of 01.
 - Required: all outputs take reset values; after release, the next tx byte is F4.

Source files
------------

// File: rtl/kbd_pkg.sv
// Shared types and constants for the keyboard command sequencer: FSM state
// encoding, protocol bytes, the power-up command ROM and default parameters.
package kbd_pkg;

    localparam int ACK_TIMEOUT_DEF = 2000;
    localparam int MAX_RETRY_DEF   = 2;

    localparam logic [7:0] KBD_ACK    = 8'hFA;
    localparam logic [7:0] KBD_RESEND = 8'hFE;

    localparam logic [1:0] INIT_LAST = 2'd2;

    typedef enum logic [2:0] {
        ST_INIT_SEND = 3'd0,
        ST_INIT_TXW  = 3'd1,
        ST_INIT_ACK  = 3'd2,
        ST_READY     = 3'd3,
        ST_HOST_TXW  = 3'd4,
        ST_HOST_ACK  = 3'd5,
        ST_ERROR     = 3'd6
    } kbd_state_e;

    // Power-up sequence: enable scanning, select scan-code set, set 1.
    function automatic logic [7:0] init_rom(input logic [1:0] idx);
        case (idx)
            2'd0:    return 8'hF4;
            2'd1:    return 8'hF0;
            default: return 8'h01;
        endcase
    endfunction

endpackage

// File: rtl/kbd_cmd_sequencer_if.sv
// Bundle between the sequencer, the keyboard serial transmitter/receiver and
// the host. The master modport is the sequencer side.
interface kbd_cmd_sequencer_if;
    logic [7:0] tx_data;
    logic       tx_start;
    logic       tx_busy;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       cmd_valid;
    logic [7:0] cmd_data;
    logic       cmd_ready;
    logic       cmd_done;
    logic       scan_valid;
    logic [7:0] scan_data;
    logic       init_done;
    logic       err;

    modport master (
        output tx_data, tx_start, cmd_ready, cmd_done, scan_valid, scan_data, init_done, err,
        input  tx_busy, rx_data, rx_valid, cmd_valid, cmd_data
    );

    modport slave (
        input  tx_data, tx_start, cmd_ready, cmd_done, scan_valid, scan_data, init_done, err,
        output tx_busy, rx_data, rx_valid, cmd_valid, cmd_data
    );
endinterface

// File: rtl/kbd_ack_timer.sv
// Acknowledge-wait counter: counts enabled cycles and flags the last allowed
// cycle so the sequencer can retry or give up.
module kbd_ack_timer
    import kbd_pkg::*;
#(
    parameter int ACK_TIMEOUT = ACK_TIMEOUT_DEF
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic enable,
    output logic expired
);
    localparam int CNT_W = $clog2(ACK_TIMEOUT + 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    assign expired = enable && (cnt_q == CNT_W'(ACK_TIMEOUT - 1));

    always_comb begin
        cnt_d = cnt_q;
        if (clear) begin
            cnt_d = '0;
        end else if (enable && !expired) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end
endmodule

// File: rtl/kbd_cmd_sequencer.sv
// PS/2 keyboard command sequencer: runs the power-up command ROM, then relays
// host commands and forwards scan bytes. Define KBD_CMD_RESEND_EN to treat a
// keyboard RESEND (FE) during an acknowledge wait like a timeout.
module kbd_cmd_sequencer
    import kbd_pkg::*;
#(
    parameter int ACK_TIMEOUT = ACK_TIMEOUT_DEF,
    parameter int MAX_RETRY   = MAX_RETRY_DEF
) (
    input  logic                KBD_CLK,
    input  logic                KBD_RESET_N,
    kbd_cmd_sequencer_if.master bus
);
    localparam int RETRY_W = (MAX_RETRY < 1) ? 1 : $clog2(MAX_RETRY + 1);

`ifdef KBD_CMD_RESEND_EN
    localparam bit RESEND_EN = 1'b1;
`else
    localparam bit RESEND_EN = 1'b0;
`endif

    kbd_state_e       state_q, state_d;
    logic [1:0]       idx_q, idx_d;
    logic [RETRY_W-1:0] retry_q, retry_d;
    logic             busy_seen_q, busy_seen_d;
    logic [7:0]       tx_data_q, tx_data_d;
    logic             tx_start_q, tx_start_d;
    logic             cmd_done_q, cmd_done_d;
    logic             scan_valid_q, scan_valid_d;
    logic [7:0]       scan_data_q, scan_data_d;
    logic             init_done_q, init_done_d;
    logic             err_q, err_d;

    logic in_ack, tmr_expired, cmd_ready, cmd_accept;
    logic rx_ack, rx_resend, retry_now, fwd_ok;

    assign in_ack     = (state_q == ST_INIT_ACK) || (state_q == ST_HOST_ACK);
    assign cmd_ready  = (state_q == ST_READY) && !bus.tx_busy;
    assign cmd_accept = bus.cmd_valid && cmd_ready;
    assign rx_ack     = bus.rx_valid && (bus.rx_data == KBD_ACK);
    assign rx_resend  = RESEND_EN && bus.rx_valid && (bus.rx_data == KBD_RESEND);
    // An FA wins over a timeout or resend arriving in the same cycle.
    assign retry_now  = !rx_ack && (tmr_expired || rx_resend);

    kbd_ack_timer #(.ACK_TIMEOUT(ACK_TIMEOUT)) u_ack_timer (
        .clk     (KBD_CLK),
        .rst_n   (KBD_RESET_N),
        .clear   (!in_ack),
        .enable  (in_ack),
        .expired (tmr_expired)
    );

    always_comb begin
        state_d      = state_q;
        idx_d        = idx_q;
        retry_d      = retry_q;
        busy_seen_d  = busy_seen_q;
        tx_data_d    = tx_data_q;
        tx_start_d   = 1'b0;
        cmd_done_d   = 1'b0;
        scan_valid_d = 1'b0;
        scan_data_d  = scan_data_q;
        init_done_d  = init_done_q;
        err_d        = err_q;
        fwd_ok       = 1'b0;

        case (state_q)
            ST_INIT_SEND: begin
                tx_start_d  = 1'b1;
                tx_data_d   = init_rom(idx_q);
                busy_seen_d = 1'b0;
                state_d     = ST_INIT_TXW;
            end
            ST_INIT_TXW, ST_HOST_TXW: begin
                if (bus.tx_busy) begin
                    busy_seen_d = 1'b1;
                end else if (busy_seen_q) begin
                    state_d = (state_q == ST_INIT_TXW) ? ST_INIT_ACK : ST_HOST_ACK;
                end
            end
            ST_INIT_ACK: begin
                if (rx_ack) begin
                    retry_d = '0;
                    if (idx_q == INIT_LAST) begin
                        init_done_d = 1'b1;
                        state_d     = ST_READY;
                    end else begin
                        idx_d   = idx_q + 2'd1;
                        state_d = ST_INIT_SEND;
                    end
                end else if (retry_now) begin
                    if (retry_q < RETRY_W'(MAX_RETRY)) begin
                        retry_d = retry_q + RETRY_W'(1);
                        state_d = ST_INIT_SEND;
                    end else begin
                        err_d   = 1'b1;
                        state_d = ST_ERROR;
                    end
                end
            end
            ST_READY: begin
                fwd_ok = 1'b1;
                if (cmd_accept) begin
                    tx_data_d   = bus.cmd_data;
                    tx_start_d  = 1'b1;
                    busy_seen_d = 1'b0;
                    state_d     = ST_HOST_TXW;
                end
            end
            ST_HOST_ACK: begin
                fwd_ok = !rx_ack && !rx_resend;
                if (rx_ack) begin
                    retry_d    = '0;
                    cmd_done_d = 1'b1;
                    state_d    = ST_READY;
                end else if (retry_now) begin
                    if (retry_q < RETRY_W'(MAX_RETRY)) begin
                        // tx_data_q still holds the host byte, so resend it directly.
                        retry_d     = retry_q + RETRY_W'(1);
                        tx_start_d  = 1'b1;
                        busy_seen_d = 1'b0;
                        state_d     = ST_HOST_TXW;
                    end else begin
                        err_d   = 1'b1;
                        state_d = ST_ERROR;
                    end
                end
            end
            ST_ERROR: begin
                err_d = 1'b1;
            end
            default: begin
                state_d = ST_INIT_SEND;
            end
        endcase

        if (bus.rx_valid && fwd_ok) begin
            scan_valid_d = 1'b1;
            scan_data_d  = bus.rx_data;
        end
    end

    always_ff @(posedge KBD_CLK) begin
        if (!KBD_RESET_N) begin
            state_q      <= ST_INIT_SEND;
            idx_q        <= '0;
            retry_q      <= '0;
            busy_seen_q  <= 1'b0;
            tx_data_q    <= 8'h00;
            tx_start_q   <= 1'b0;
            cmd_done_q   <= 1'b0;
            scan_valid_q <= 1'b0;
            scan_data_q  <= 8'h00;
            init_done_q  <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            retry_q      <= retry_d;
            busy_seen_q  <= busy_seen_d;
            tx_data_q    <= tx_data_d;
            tx_start_q   <= tx_start_d;
            cmd_done_q   <= cmd_done_d;
            scan_valid_q <= scan_valid_d;
            scan_data_q  <= scan_data_d;
            init_done_q  <= init_done_d;
            err_q        <= err_d;
        end
    end

    assign bus.tx_data    = tx_data_q;
    assign bus.tx_start   = tx_start_q;
    assign bus.cmd_ready  = cmd_ready;
    assign bus.cmd_done   = cmd_done_q;
    assign bus.scan_valid = scan_valid_q;
    assign bus.scan_data  = scan_data_q;
    assign bus.init_done  = init_done_q;
    assign bus.err        = err_q;
endmodule

// File: tb/tb_kbd_cmd_sequencer.sv
// Directed bench for kbd_cmd_sequencer with a transmitter/keyboard model that
// holds tx_busy 12 cycles per frame and replies two cycles after the frame.
`timescale 1ns/1ps
module tb_kbd_cmd_sequencer;
    localparam int T_ACK    = 50;
    localparam int T_RETRY  = 2;
    localparam int BUSY_CYC = 12;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    kbd_cmd_sequencer_if bus();

    kbd_cmd_sequencer #(.ACK_TIMEOUT(T_ACK), .MAX_RETRY(T_RETRY)) dut (
        .KBD_CLK     (clk),
        .KBD_RESET_N (rst_n),
        .bus         (bus.master)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    logic [7:0] tx_log[$];
    int         tx_cyc[$];
    logic [7:0] scan_log[$];
    logic [7:0] inject_q[$];
    int         reply_q[$];
    bit         auto_ack = 1'b1;
    int lat_err = 0;
    int done_cnt = 0;
    int busy_left = 0;
    int reply_delay = 0;
    logic [7:0] reply_byte = 8'h00;
    bit start_seen = 1'b0;
    logic p_v;
    logic [7:0] p_d;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] txget(input int i);
        if (i < tx_log.size()) return tx_log[i];
        return 8'bx;
    endfunction

    function automatic logic [7:0] scget(input int i);
        if (i < scan_log.size()) return scan_log[i];
        return 8'bx;
    endfunction

    function automatic int cget(input int i);
        if (i < tx_cyc.size()) return tx_cyc[i];
        return -1000;
    endfunction

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic clear_logs();
        tx_log.delete(); tx_cyc.delete(); scan_log.delete();
        inject_q.delete(); reply_q.delete();
        lat_err = 0; done_cnt = 0; auto_ack = 1'b1;
    endtask

    // Transmitter, keyboard and output monitor, stepping 1 ns after each edge.
    initial begin
        int r;
        bus.tx_busy = 1'b0; bus.rx_valid = 1'b0; bus.rx_data = 8'h00;
        forever begin
            @(posedge clk); #1;
            cyc++;
            p_v = bus.rx_valid;
            p_d = bus.rx_data;
            bus.rx_valid = 1'b0;
            if (reply_delay > 0) begin
                reply_delay--;
                if (reply_delay == 0) begin
                    bus.rx_valid = 1'b1;
                    bus.rx_data  = reply_byte;
                end
            end else if (inject_q.size() > 0) begin
                bus.rx_valid = 1'b1;
                bus.rx_data  = inject_q.pop_front();
            end
            if (busy_left > 0) begin
                busy_left--;
                if (busy_left == 0) begin
                    bus.tx_busy = 1'b0;
                    if (reply_q.size() > 0) r = reply_q.pop_front();
                    else r = auto_ack ? 'hFA : -1;
                    if (r >= 0) begin
                        reply_delay = 2;
                        reply_byte  = r[7:0];
                    end
                end
            end
            if (start_seen) begin
                bus.tx_busy = 1'b1;
                busy_left   = BUSY_CYC;
                start_seen  = 1'b0;
            end
            if (bus.tx_start) begin
                tx_log.push_back(bus.tx_data);
                tx_cyc.push_back(cyc);
                start_seen = 1'b1;
            end
            if (bus.scan_valid) begin
                scan_log.push_back(bus.scan_data);
                if (!(p_v && p_d == bus.scan_data)) lat_err++;
            end
            if (bus.cmd_done) done_cnt++;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int rel;
        int exp_gap;
        bus.cmd_valid = 1'b0;
        bus.cmd_data  = 8'h00;

        // Reset values
        rst_n = 1'b0;
        tick(3);
        chk("rst_tx_start",   32'(bus.tx_start),   0);
        chk("rst_tx_data",    32'(bus.tx_data),    0);
        chk("rst_cmd_ready",  32'(bus.cmd_ready),  0);
        chk("rst_cmd_done",   32'(bus.cmd_done),   0);
        chk("rst_scan_valid", 32'(bus.scan_valid), 0);
        chk("rst_scan_data",  32'(bus.scan_data),  0);
        chk("rst_init_done",  32'(bus.init_done),  0);
        chk("rst_err",        32'(bus.err),        0);

        // Normal init: F4, F0, 01 each acknowledged
        clear_logs();
        rst_n = 1'b1;
        rel = cyc;
        for (int k = 0; k < 300 && !bus.init_done; k++) tick(1);
        chk("init_done",  32'(bus.init_done), 1);
        chk("init_n_tx",  32'(tx_log.size()), 3);
        chk("init_tx0",   32'(txget(0)), 'hF4);
        chk("init_tx1",   32'(txget(1)), 'hF0);
        chk("init_tx2",   32'(txget(2)), 'h01);
        chk("init_lat",   32'(cget(0) - rel), 1);
        chk("init_err",   32'(bus.err), 0);
        tick(1);
        chk("ready_cmd_ready", 32'(bus.cmd_ready), 1);

        // Scan forwarding in READY
        scan_log.delete(); lat_err = 0;
        inject_q.push_back(8'h1C);
        inject_q.push_back(8'h32);
        tick(6);
        chk("scan_n",   32'(scan_log.size()), 2);
        chk("scan0",    32'(scscan0()), 'h1C);
        chk("scan1",    32'(scget(1)), 'h32);
        chk("scan_lat", 32'(lat_err), 0);

        // Host command ED with simultaneous scan byte, 2A during the wait, then FA
        clear_logs();
        auto_ack = 1'b0;
        inject_q.push_back(8'h1C);
        tick(1);
        bus.cmd_valid = 1'b1;
        bus.cmd_data  = 8'hED;
        chk("host_cmd_ready", 32'(bus.cmd_ready), 1);
        tick(1);
        bus.cmd_valid = 1'b0;
        for (int k = 0; k < 20 && !bus.tx_busy; k++) tick(1);
        for (int k = 0; k < 30 && bus.tx_busy; k++) tick(1);
        chk("host_frame_end", 32'(bus.tx_busy), 0);
        tick(2);
        inject_q.push_back(8'h2A);
        tick(3);
        inject_q.push_back(8'hFA);
        tick(6);
        chk("host_n_tx",   32'(tx_log.size()), 1);
        chk("host_tx",     32'(txget(0)), 'hED);
        chk("host_scan_n", 32'(scan_log.size()), 2);
        chk("host_scan0",  32'(scget(0)), 'h1C);
        chk("host_scan1",  32'(scget(1)), 'h2A);
        chk("host_done_n", 32'(done_cnt), 1);
        chk("host_lat",    32'(lat_err), 0);
        chk("host_ready",  32'(bus.cmd_ready), 1);

        // FE reply to the first F4
        rst_n = 1'b0;
        tick(3);
        clear_logs();
        reply_q.push_back('hFE);
        rst_n = 1'b1;
        for (int k = 0; k < 400 && tx_log.size() < 3; k++) tick(1);
        chk("rs_tx0", 32'(txget(0)), 'hF4);
        chk("rs_tx1", 32'(txget(1)), 'hF4);
        chk("rs_tx2", 32'(txget(2)), 'hF0);
`ifdef KBD_CMD_RESEND_EN
        exp_gap = 17;
`else
        exp_gap = 65;
`endif
        chk("rs_gap", 32'(cget(1) - cget(0)), 32'(exp_gap));
        for (int k = 0; k < 200 && !bus.init_done; k++) tick(1);
        chk("rs_init_done", 32'(bus.init_done), 1);
        chk("rs_err",       32'(bus.err), 0);

        // No reply to F0: three attempts then ERROR
        rst_n = 1'b0;
        tick(3);
        clear_logs();
        auto_ack = 1'b0;
        reply_q.push_back('hFA);
        rst_n = 1'b1;
        for (int k = 0; k < 600 && !bus.err; k++) tick(1);
        chk("to_err",     32'(bus.err), 1);
        chk("to_n_tx",    32'(tx_log.size()), 4);
        chk("to_tx1",     32'(txget(1)), 'hF0);
        chk("to_tx2",     32'(txget(2)), 'hF0);
        chk("to_tx3",     32'(txget(3)), 'hF0);
        chk("to_gap1",    32'(cget(2) - cget(1)), 65);
        chk("to_gap2",    32'(cget(3) - cget(2)), 65);
        chk("to_init",    32'(bus.init_done), 0);
        scan_log.delete();
        inject_q.push_back(8'h1C);
        bus.cmd_valid = 1'b1;
        bus.cmd_data  = 8'hED;
        tick(4);
        chk("to_cmd_ready", 32'(bus.cmd_ready), 0);
        bus.cmd_valid = 1'b0;
        tick(2);
        chk("to_scan_n",  32'(scan_log.size()), 0);
        chk("to_n_tx2",   32'(tx_log.size()), 4);
        chk("to_err_hold", 32'(bus.err), 1);

        // Reset during the 01 frame
        rst_n = 1'b0;
        tick(3);
        clear_logs();
        rst_n = 1'b1;
        for (int k = 0; k < 300 && tx_log.size() < 3; k++) tick(1);
        tick(3);
        chk("mid_tx2", 32'(txget(2)), 'h01);
        rst_n = 1'b0;
        tick(2);
        chk("mid_tx_start",   32'(bus.tx_start),   0);
        chk("mid_tx_data",    32'(bus.tx_data),    0);
        chk("mid_cmd_ready",  32'(bus.cmd_ready),  0);
        chk("mid_cmd_done",   32'(bus.cmd_done),   0);
        chk("mid_scan_valid", 32'(bus.scan_valid), 0);
        chk("mid_scan_data",  32'(bus.scan_data),  0);
        chk("mid_init_done",  32'(bus.init_done),  0);
        chk("mid_err",        32'(bus.err),        0);
        tick(25);
        clear_logs();
        rst_n = 1'b1;
        rel = cyc;
        for (int k = 0; k < 20 && tx_log.size() < 1; k++) tick(1);
        chk("mid_restart_tx",  32'(txget(0)), 'hF4);
        chk("mid_restart_lat", 32'(cget(0) - rel), 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    function automatic logic [7:0] scscan0();
        return scget(0);
    endfunction
endmodule
